guess_entry: RTL
================

GUESS_ENTRY -- requirements
Module: guess_entry

Interface
REQ-001 Parameter WORD_LEN, default 5: number of letters per guess.
REQ-002 Parameter ALPHA, default 26: letter codes 0..ALPHA-1, where 0 = 'A'.
REQ-003 clk_sys  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 btn_up  input  1  debounced level; a rising edge advances the current letter.
REQ-006 btn_down  input  1  debounced level; a rising edge steps the current letter back.
REQ-007 btn_add  input  1  debounced level; a rising edge appends the current letter to the guess.
REQ-008 btn_del  input  1  debounced level; a rising edge removes the last letter.
REQ-009 btn_enter  input  1  debounced level; a rising edge submits a full guess.
REQ-010 guess_ack  input  1  consumer accepts the submitted guess.
REQ-011 cur_letter  output  5  letter currently selected for entry.
REQ-012 guess  output  5*WORD_LEN  entered letters; slot i occupies bits [5i+4:5i].
REQ-013 guess_len  output  3  number of letters entered, 0..WORD_LEN.
REQ-014 guess_valid  output  1  submitted guess available to the consumer.
REQ-015 state  output  2  FSM state: EDIT=0, FULL=1, SUBMIT=2.

Function
REQ-016 Each btn_* SHALL be edge-detected against a registered previous value: event = btn & ~prev. A level held high yields exactly one event.
REQ-017 Only one event SHALL be acted on per cycle. Priority: enter > del > add > up > down. Lower-priority events in that cycle are discarded.
REQ-018 Event effects SHALL be registered at the same clk_sys edge that first samples the button high, so outputs are visible one cycle after the input rises.
REQ-019 EDIT, up event: cur_letter increments; ALPHA-1 wraps to 0.
REQ-020 EDIT, down event: cur_letter decrements; 0 wraps to ALPHA-1.
REQ-021 EDIT, add event:
- slot[guess_len] <= cur_letter
- guess_len increments
- cur_letter <= 0
- if guess_len becomes WORD_LEN, state <= FULL
REQ-022 EDIT, del event with guess_len>0: guess_len decrements, the vacated slot is cleared to 0, and cur_letter is unchanged.
REQ-023 EDIT, del event with guess_len=0: no effect.
REQ-024 EDIT, enter event: ignored.
REQ-025 FULL, up/down/add events: ignored.
REQ-026 FULL, del event: guess_len <= WORD_LEN-1, last slot cleared, state <= EDIT.
REQ-027 FULL, enter event: state <= SUBMIT and guess_valid <= 1 at the same edge.
REQ-028 SUBMIT:
- guess_valid held at 1
- guess and guess_len held stable
- all button events ignored, but prev registers keep tracking the inputs
REQ-029 SUBMIT with guess_ack=1:
- guess cleared to 0, guess_len <= 0, cur_letter <= 0, guess_valid <= 0
- state <= EDIT at that edge
REQ-030 guess_ack SHALL be ignored outside SUBMIT.
REQ-031 A button event in the same cycle as guess_ack SHALL be discarded.
REQ-032 State encoding 3 is unreachable; if entered, the FSM returns to EDIT on the next edge with all outputs cleared.

Reset
REQ-033 rst=1 SHALL immediately force: state=EDIT, cur_letter=0, guess=0, guess_len=0, guess_valid=0.
REQ-034 All prev registers SHALL reset to 1, so a button held through reset release produces no event.
REQ-035 rst asserted mid-SUBMIT SHALL drop guess_valid asynchronously and discard the pending guess.

Verification
REQ-036 Three up pulses, then add -> cur_letter shows 3 before the add, then 0 after; slot0=3; guess_len=1.
REQ-037 One down pulse from reset -> cur_letter=25. Then 26 up pulses -> cur_letter=25 again (wrap verified).
REQ-038 Add letters 7,4,11,11,14 -> state=FULL and guess_len=5. Then up and add pulses -> no change. Then del -> guess_len=4, slot4=0, state=EDIT.
REQ-039 Full guess, then enter -> guess_valid=1 one cycle later. Hold 10 cycles with button pulses -> guess unchanged. Then guess_ack -> next cycle guess=0, guess_len=0, guess_valid=0, state=EDIT.
REQ-040 btn_add and btn_del rise in the same cycle with guess_len=2 -> guess_len=1 (del wins), and add is not applied later.
REQ-041 btn_up held high across rst deassertion for 100 cycles -> cur_letter stays 0. Release and press again -> cur_letter=1.

Source files
------------

// File: rtl/guess_entry.sv
// ---------------------------------------------------------------------------
// guess_entry
// Letter-by-letter entry of a fixed-length word guess from five debounced
// push buttons, with a valid/ack handshake toward the consumer.
//
// Parameters
//   WORD_LEN  letters per guess (guess_len is 3 bits, so at most 7)
//   ALPHA     letter codes 0..ALPHA-1, 0 = 'A' (cur_letter is 5 bits)
//
// Ports
//   clk_sys      in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   btn_up       in   rising edge: next letter (wraps)
//   btn_down     in   rising edge: previous letter (wraps)
//   btn_add      in   rising edge: append current letter
//   btn_del      in   rising edge: remove last letter
//   btn_enter    in   rising edge: submit a full guess
//   guess_ack    in   consumer takes the submitted guess (SUBMIT only)
//   cur_letter   out  letter selected for entry
//   guess        out  entered letters, slot i at bits [5i+4:5i]
//   guess_len    out  number of letters entered
//   guess_valid  out  submitted guess is available
//   state        out  EDIT=0, FULL=1, SUBMIT=2
// ---------------------------------------------------------------------------
module guess_entry #(
    parameter int unsigned WORD_LEN = 5,
    parameter int unsigned ALPHA    = 26
) (
    input  logic                    clk_sys,
    input  logic                    rst,
    input  logic                    btn_up,
    input  logic                    btn_down,
    input  logic                    btn_add,
    input  logic                    btn_del,
    input  logic                    btn_enter,
    input  logic                    guess_ack,
    output logic [4:0]              cur_letter,
    output logic [5*WORD_LEN-1:0]   guess,
    output logic [2:0]              guess_len,
    output logic                    guess_valid,
    output logic [1:0]              state
);

    localparam int unsigned LW = 5;
    localparam int unsigned GW = LW * WORD_LEN;
    localparam int unsigned NB = 5;

    localparam logic [1:0] ST_EDIT   = 2'd0;
    localparam logic [1:0] ST_FULL   = 2'd1;
    localparam logic [1:0] ST_SUBMIT = 2'd2;

    localparam logic [2:0]    LEN_MAX    = 3'(WORD_LEN);
    localparam logic [LW-1:0] LETTER_MAX = LW'(ALPHA - 1);

    // Button bit order, highest priority first: enter, del, add, up, down
    localparam int unsigned B_ENTER = 4;
    localparam int unsigned B_DEL   = 3;
    localparam int unsigned B_ADD   = 2;
    localparam int unsigned B_UP    = 1;
    localparam int unsigned B_DOWN  = 0;

    logic [NB-1:0] btn_vec;
    logic [NB-1:0] prev;
    logic [NB-1:0] rise_c;
    logic [NB-1:0] ev_c;

    logic [1:0]    state_n;
    logic [LW-1:0] cur_n;
    logic [GW-1:0] guess_n;
    logic [2:0]    len_n;
    logic          valid_n;

    assign btn_vec = {btn_enter, btn_del, btn_add, btn_up, btn_down};

    // Rising edges against the previous sample
    assign rise_c = btn_vec & ~prev;

    // Keep only the highest-priority event of the cycle
    always_comb begin
        ev_c = '0;
        if (rise_c[B_ENTER])     ev_c[B_ENTER] = 1'b1;
        else if (rise_c[B_DEL])  ev_c[B_DEL]   = 1'b1;
        else if (rise_c[B_ADD])  ev_c[B_ADD]   = 1'b1;
        else if (rise_c[B_UP])   ev_c[B_UP]    = 1'b1;
        else if (rise_c[B_DOWN]) ev_c[B_DOWN]  = 1'b1;
    end

    // State and output registers; prev resets high so held buttons stay quiet
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            prev        <= '1;
            state       <= ST_EDIT;
            cur_letter  <= '0;
            guess       <= '0;
            guess_len   <= '0;
            guess_valid <= 1'b0;
        end else begin
            prev        <= btn_vec;
            state       <= state_n;
            cur_letter  <= cur_n;
            guess       <= guess_n;
            guess_len   <= len_n;
            guess_valid <= valid_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        cur_n   = cur_letter;
        guess_n = guess;
        len_n   = guess_len;
        valid_n = guess_valid;

        case (state)
            ST_EDIT: begin
                valid_n = 1'b0;
                if (ev_c[B_DEL]) begin
                    if (guess_len != 3'd0) begin
                        len_n = guess_len - 3'd1;
                        for (int unsigned i = 0; i < WORD_LEN; i++) begin
                            if (3'(i) == len_n) guess_n[LW*i +: LW] = '0;
                        end
                    end
                end else if (ev_c[B_ADD]) begin
                    for (int unsigned i = 0; i < WORD_LEN; i++) begin
                        if (3'(i) == guess_len) guess_n[LW*i +: LW] = cur_letter;
                    end
                    len_n = guess_len + 3'd1;
                    cur_n = '0;
                    if (len_n == LEN_MAX) state_n = ST_FULL;
                end else if (ev_c[B_UP]) begin
                    cur_n = (cur_letter == LETTER_MAX) ? '0 : cur_letter + LW'(1);
                end else if (ev_c[B_DOWN]) begin
                    cur_n = (cur_letter == '0) ? LETTER_MAX : cur_letter - LW'(1);
                end
                // enter in EDIT is ignored and still masks lower events
            end

            ST_FULL: begin
                valid_n = 1'b0;
                if (ev_c[B_ENTER]) begin
                    state_n = ST_SUBMIT;
                    valid_n = 1'b1;
                end else if (ev_c[B_DEL]) begin
                    len_n = LEN_MAX - 3'd1;
                    guess_n[LW*(WORD_LEN-1) +: LW] = '0;
                    state_n = ST_EDIT;
                end
            end

            ST_SUBMIT: begin
                // Guess frozen until the consumer takes it; buttons ignored
                valid_n = 1'b1;
                if (guess_ack) begin
                    guess_n = '0;
                    len_n   = '0;
                    cur_n   = '0;
                    valid_n = 1'b0;
                    state_n = ST_EDIT;
                end
            end

            default: begin
                // Unreachable encoding: recover cleanly
                guess_n = '0;
                len_n   = '0;
                cur_n   = '0;
                valid_n = 1'b0;
                state_n = ST_EDIT;
            end
        endcase
    end

endmodule
